rf_write_queue: RTL

// - Buffers pending register writes from multi-cycle producers (loads, ALU
//   ops) and issues them one per cycle to the register file write port.
// - Sits between the producers and the register file write port
//   (RegWrite/WriteReg/WriteData). The pipeline's own writeback has priority.
// - Two lookup ports give the youngest pending value per register so that

---
 rtl/rf_write_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/rf_write_queue.sv
// Circular write queue between multi-cycle producers and the register file
// write port; pipeline writeback has priority, lookups return youngest pending data.
module rf_write_queue #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     port_busy,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        look_addr1,
  output logic                     look_hit1,
  output logic [DATA_W-1:0]        look_data1,
  input  logic [ADDR_W-1:0]        look_addr2,
  output logic                     look_hit2,
  output logic [DATA_W-1:0]        look_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a push happens on an edge where in_valid & in_ready are both
  // high; a pop happens on an edge where RegWrite is high.

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [PTR_W-1:0]  idx;

  assign in_ready  = (count_q != CNT_W'(DEPTH)) && !reset;
  assign RegWrite  = (count_q != '0) && !port_busy && !reset;
  assign WriteReg  = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
  assign WriteData = (count_q != '0) ? data_q[rd_ptr_q] : '0;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = RegWrite;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      addr_d[wr_ptr_q] = in_addr;
      data_d[wr_ptr_q] = in_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    look_hit1  = 1'b0;
    look_data1 = '0;
    look_hit2  = 1'b0;
    look_data2 = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && !reset) begin
        if (addr_q[idx] == look_addr1) begin
          look_hit1  = 1'b1;
          look_data1 = data_q[idx];
        end
        if (addr_q[idx] == look_addr2) begin
          look_hit2  = 1'b1;
          look_data2 = data_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
